key_event_ctrl: RTL and testbench
=================================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, event FIFO depth in entries; power of two, minimum 2.
REQ-002 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port i_sclr  input  1  reset, synchronous, active-high.
REQ-004 Port i_byte_en  input  1  one-cycle strobe marking i_byte valid.
REQ-005 Port i_byte  input  8  received PS/2 byte.
REQ-006 Port i_event_ready  input  1  consumer accepts the head event this cycle.
REQ-007 Port o_event_valid  output  1  FIFO non-empty; head event presented.
REQ-008 Port o_scancode  output  8  head event scancode (final non-prefix byte).
REQ-009 Port o_break  output  1  head event is a key release (F0 prefix seen).
REQ-010 Port o_ext  output  1  head event is an extended key (E0 prefix seen).
REQ-011 Port o_overflow  output  1  sticky: at least one event was dropped because the FIFO was full.
REQ-012 Port o_count  output  $clog2(DEPTH)+1  number of events held.

Function
REQ-013 Prefix FSM states: IDLE, EXT, BRK, EXT_BRK; it advances only on cycles with i_byte_en=1.
REQ-014 IDLE: E0 -> EXT; F0 -> BRK; other key byte -> emit {ext=0, brk=0, code}, stay IDLE.
REQ-015 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other key byte -> emit {ext=1, brk=0}, go IDLE.
REQ-016 BRK: other key byte -> emit {ext=0, brk=1}, go IDLE; E0 -> EXT_BRK; F0 -> stay BRK.
REQ-017 EXT_BRK: other key byte -> emit {ext=1, brk=1}, go IDLE; E0/F0 -> stay EXT_BRK.
REQ-018 Bytes 00, FF, AA, FA, FE and E1 are non-key bytes: no event is emitted and the FSM goes to IDLE from any state.
REQ-019 An emitted event is written to the FIFO in the same cycle as the final byte; o_event_valid rises on the next cycle (latency 1 from the final i_byte_en).
REQ-020 FIFO is first-word-fall-through: o_scancode, o_break and o_ext always show the head entry while o_event_valid=1; they hold their last value when empty.
REQ-021 Pop occurs when o_event_valid & i_event_ready; i_event_ready while empty is ignored.
REQ-022 Push while full with no pop in the same cycle: the event is dropped, the FIFO is unchanged, and o_overflow is set.
REQ-023 Push and pop in the same cycle while full: both take effect and o_count is unchanged.
REQ-024 Push and pop in the same cycle while non-empty and not full: both take effect; ordering is preserved.
REQ-025 Read/write pointers wrap modulo DEPTH; o_count ranges 0..DEPTH.
REQ-026 o_overflow clears only on i_sclr.

Reset
REQ-027 On i_sclr=1: FSM=IDLE, pointers=0, o_count=0, o_event_valid=0, o_overflow=0, o_scancode=00, o_break=0, o_ext=0.
REQ-028 i_sclr takes priority over i_byte_en and i_event_ready in the same cycle; a partially received prefix sequence is discarded.

Structure
REQ-029 Byte constants (E0, F0, E1, 00, FF, AA, FA, FE), FSM state encodings and the event-word layout {ext, brk, code[7:0]} are defined in the shared kb defines header.
REQ-030 Storage is a sub-module event_fifo: DEPTH x 10-bit synchronous FIFO with push/pop/full/empty/count, using the same clk and i_sclr.

Verification
REQ-031 Bytes 1C -> one event {code=1C, brk=0, ext=0}, o_event_valid high exactly 1 cycle after the strobe, o_count=1.
REQ-032 Bytes F0,1C then E0,75 then E0,F0,75 -> three events in order: {1C, brk=1, ext=0}, {75, brk=0, ext=1}, {75, brk=1, ext=1}.
REQ-033 With i_event_ready=0, five key bytes 15,16,17,18,19 -> o_count=4, o_overflow=1; popping yields 15,16,17,18.
REQ-034 FIFO full, final byte 2A sent in the same cycle as a pop -> o_count stays 4, o_overflow stays 0, 2A is at the tail.
REQ-035 Bytes E0,F0 then AA then 1C -> a single event {1C, brk=0, ext=0}.
REQ-036 Bytes F0, then i_sclr pulse, then 1C -> a single event {1C, brk=0, ext=0}; all outputs equal their reset values in the cycle after i_sclr.

Source files
------------

// File: rtl/key_event_ctrl_pkg.sv
// Shared PS/2 keyboard definitions: byte constants, prefix FSM states, event word.
package key_event_ctrl_pkg;

  localparam logic [7:0] KB_E0 = 8'hE0;
  localparam logic [7:0] KB_F0 = 8'hF0;
  localparam logic [7:0] KB_E1 = 8'hE1;
  localparam logic [7:0] KB_00 = 8'h00;
  localparam logic [7:0] KB_FF = 8'hFF;
  localparam logic [7:0] KB_AA = 8'hAA;
  localparam logic [7:0] KB_FA = 8'hFA;
  localparam logic [7:0] KB_FE = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kb_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kb_event_t;

  localparam int unsigned KB_EVENT_W = $bits(kb_event_t);

  // Bytes that carry no key information and abort any pending prefix.
  function automatic logic kb_is_non_key(input logic [7:0] b);
    return (b == KB_00) || (b == KB_FF) || (b == KB_AA) ||
           (b == KB_FA) || (b == KB_FE) || (b == KB_E1);
  endfunction

endpackage

// File: rtl/key_event_ctrl_event_fifo.sv
// First-word-fall-through event FIFO; head register holds the last entry once drained.
module event_fifo
  import key_event_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             i_sclr,
  input  logic                             i_push,
  input  logic                             i_pop,
  input  logic [KB_EVENT_W-1:0]            i_wdata,
  output logic [KB_EVENT_W-1:0]            o_head,
  output logic                             o_full,
  output logic                             o_empty,
  output logic [$clog2(DEPTH):0]           o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [KB_EVENT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [KB_EVENT_W-1:0] head_q, head_d;
  logic                  do_push_c;
  logic                  do_pop_c;

  // Pointer, occupancy and head-of-queue next-state.
  always_comb begin
    do_pop_c  = i_pop & ~empty_q;
    do_push_c = i_push & (~full_q | do_pop_c);
    wr_ptr_d  = wr_ptr_q + AW'(do_push_c);
    rd_ptr_d  = rd_ptr_q + AW'(do_pop_c);
    count_d   = count_q + CW'(do_push_c) - CW'(do_pop_c);
    full_d    = (count_d == CW'(DEPTH));
    empty_d   = (count_d == '0);
    head_d    = head_q;
    if (!empty_d) begin
      // When only the incoming entry remains, it bypasses the array.
      if ((count_q - CW'(do_pop_c)) == '0) begin
        head_d = i_wdata;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      head_q   <= head_d;
    end
  end

  assign o_head  = head_q;
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_count = count_q;

endmodule

// File: rtl/key_event_ctrl.sv
// PS/2 scancode prefix decoder feeding an event FIFO.
module key_event_ctrl
  import key_event_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   i_sclr,
  input  logic                   i_byte_en,
  input  logic [7:0]             i_byte,
  input  logic                   i_event_ready,
  output logic                   o_event_valid,
  output logic [7:0]             o_scancode,
  output logic                   o_break,
  output logic                   o_ext,
  output logic                   o_overflow,
  output logic [$clog2(DEPTH):0] o_count
);

  kb_state_t             state_q, state_d;
  logic                  overflow_q, overflow_d;
  logic                  push_c;
  logic                  pop_c;
  kb_event_t             event_c;
  kb_event_t             head;
  logic [KB_EVENT_W-1:0] head_raw;
  logic                  fifo_full;
  logic                  fifo_empty;

  // Prefix FSM: track E0/F0 prefixes and emit an event on the final key byte.
  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    event_c = '0;
    if (i_byte_en) begin
      if (kb_is_non_key(i_byte)) begin
        state_d = ST_IDLE;
      end else if (i_byte == KB_E0) begin
        unique case (state_q)
          ST_IDLE:  state_d = ST_EXT;
          ST_EXT:   state_d = ST_EXT;
          default:  state_d = ST_EXT_BRK;
        endcase
      end else if (i_byte == KB_F0) begin
        unique case (state_q)
          ST_IDLE:  state_d = ST_BRK;
          ST_BRK:   state_d = ST_BRK;
          default:  state_d = ST_EXT_BRK;
        endcase
      end else begin
        push_c       = 1'b1;
        event_c.code = i_byte;
        event_c.ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        event_c.brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        state_d      = ST_IDLE;
      end
    end
  end

  // Sticky overflow: an event arrived with the FIFO full and no pop to make room.
  always_comb begin
    pop_c      = i_event_ready & ~fifo_empty;
    overflow_d = overflow_q | (push_c & fifo_full & ~pop_c);
  end

  // FSM and overflow registers.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  event_fifo #(
    .DEPTH (DEPTH)
  ) u_event_fifo (
    .clk     (clk),
    .i_sclr  (i_sclr),
    .i_push  (push_c),
    .i_pop   (pop_c),
    .i_wdata (event_c),
    .o_head  (head_raw),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (o_count)
  );

  assign head          = kb_event_t'(head_raw);
  assign o_event_valid = ~fifo_empty;
  assign o_scancode    = head.code;
  assign o_break       = head.brk;
  assign o_ext         = head.ext;
  assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: vector table plus hand-written prefix sequences.
module tb_key_event_ctrl;

  logic       clk = 1'b0;
  logic       i_sclr = 1'b1;
  logic       i_byte_en = 1'b0;
  logic [7:0] i_byte = 8'h00;
  logic       i_event_ready = 1'b0;
  logic       o_event_valid;
  logic [7:0] o_scancode;
  logic       o_break;
  logic       o_ext;
  logic       o_overflow;
  logic [2:0] o_count;

  int errors = 0;
  int checks = 0;

  key_event_ctrl #(.DEPTH(4)) dut (
    .clk           (clk),
    .i_sclr        (i_sclr),
    .i_byte_en     (i_byte_en),
    .i_byte        (i_byte),
    .i_event_ready (i_event_ready),
    .o_event_valid (o_event_valid),
    .o_scancode    (o_scancode),
    .o_break       (o_break),
    .o_ext         (o_ext),
    .o_overflow    (o_overflow),
    .o_count       (o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sclr;
    logic       en;
    logic [7:0] b;
    logic       rdy;
    logic       v;
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic       ovf;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sclr, input logic en, input logic [7:0] b, input logic rdy,
                     input logic v, input logic [7:0] code, input logic brk, input logic ext,
                     input logic ovf, input logic [2:0] cnt);
    vec_t t;
    t.sclr = sclr; t.en = en; t.b = b; t.rdy = rdy;
    t.v = v; t.code = code; t.brk = brk; t.ext = ext; t.ovf = ovf; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic sclr, input logic en, input logic [7:0] b, input logic rdy);
    i_sclr = sclr; i_byte_en = en; i_byte = b; i_event_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic v, input logic [7:0] code,
                       input logic brk, input logic ext, input logic ovf, input logic [2:0] cnt);
    logic [14:0] act;
    logic [14:0] exp;
    act = {o_event_valid, o_scancode, o_break, o_ext, o_overflow, o_count};
    exp = {v, code, brk, ext, ovf, cnt};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got valid=%b code=%h brk=%b ext=%b ovf=%b cnt=%0d, want valid=%b code=%h brk=%b ext=%b ovf=%b cnt=%0d",
               name, o_event_valid, o_scancode, o_break, o_ext, o_overflow, o_count,
               v, code, brk, ext, ovf, cnt);
    end
  endtask

  initial begin
    // reset and single make code
    add(1,0,8'h00,0, 0,8'h00,0,0,0,0);
    add(0,1,8'h1C,0, 1,8'h1C,0,0,0,1);
    add(0,0,8'h00,1, 0,8'h1C,0,0,0,0);
    // break, extended, extended break
    add(0,1,8'hF0,0, 0,8'h1C,0,0,0,0);
    add(0,1,8'h1C,0, 1,8'h1C,1,0,0,1);
    add(0,1,8'hE0,0, 1,8'h1C,1,0,0,1);
    add(0,1,8'h75,0, 1,8'h1C,1,0,0,2);
    add(0,1,8'hE0,0, 1,8'h1C,1,0,0,2);
    add(0,1,8'hF0,0, 1,8'h1C,1,0,0,2);
    add(0,1,8'h75,0, 1,8'h1C,1,0,0,3);
    add(0,0,8'h00,1, 1,8'h75,0,1,0,2);
    add(0,0,8'h00,1, 1,8'h75,1,1,0,1);
    add(0,0,8'h00,1, 0,8'h75,1,1,0,0);
    add(0,0,8'h00,1, 0,8'h75,1,1,0,0);
    // overflow: fifth event dropped
    add(0,1,8'h15,0, 1,8'h15,0,0,0,1);
    add(0,1,8'h16,0, 1,8'h15,0,0,0,2);
    add(0,1,8'h17,0, 1,8'h15,0,0,0,3);
    add(0,1,8'h18,0, 1,8'h15,0,0,0,4);
    add(0,1,8'h19,0, 1,8'h15,0,0,1,4);
    add(0,0,8'h00,1, 1,8'h16,0,0,1,3);
    add(0,0,8'h00,1, 1,8'h17,0,0,1,2);
    add(0,0,8'h00,1, 1,8'h18,0,0,1,1);
    add(0,0,8'h00,1, 0,8'h18,0,0,1,0);
    // full with simultaneous push and pop
    add(1,0,8'h00,0, 0,8'h00,0,0,0,0);
    add(0,1,8'h21,0, 1,8'h21,0,0,0,1);
    add(0,1,8'h22,0, 1,8'h21,0,0,0,2);
    add(0,1,8'h23,0, 1,8'h21,0,0,0,3);
    add(0,1,8'h24,0, 1,8'h21,0,0,0,4);
    add(0,1,8'h2A,1, 1,8'h22,0,0,0,4);
    add(0,0,8'h00,1, 1,8'h23,0,0,0,3);
    add(0,0,8'h00,1, 1,8'h24,0,0,0,2);
    add(0,0,8'h00,1, 1,8'h2A,0,0,0,1);
    add(0,0,8'h00,1, 0,8'h2A,0,0,0,0);
    // non-key byte aborts prefix
    add(0,1,8'hE0,0, 0,8'h2A,0,0,0,0);
    add(0,1,8'hF0,0, 0,8'h2A,0,0,0,0);
    add(0,1,8'hAA,0, 0,8'h2A,0,0,0,0);
    add(0,1,8'h1C,0, 1,8'h1C,0,0,0,1);
    // push and pop together while partly filled
    add(0,1,8'h33,1, 1,8'h33,0,0,0,1);
    add(0,0,8'h00,1, 0,8'h33,0,0,0,0);
    // reset discards prefix and wins over byte/ready
    add(0,1,8'hF0,0, 0,8'h33,0,0,0,0);
    add(1,1,8'h1C,1, 0,8'h00,0,0,0,0);
    add(0,1,8'h1C,0, 1,8'h1C,0,0,0,1);
    add(0,0,8'h00,1, 0,8'h1C,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].sclr, vecs[i].en, vecs[i].b, vecs[i].rdy);
      check($sformatf("vec%0d", i), vecs[i].v, vecs[i].code, vecs[i].brk, vecs[i].ext,
            vecs[i].ovf, vecs[i].cnt);
    end

    // Hand sequence: repeated prefixes, E0 then non-key, F0 then E1.
    step(1, 0, 8'h00, 0);
    check("seq_reset", 0, 8'h00, 0, 0, 0, 0);
    step(0, 1, 8'hF0, 0);
    step(0, 1, 8'hF0, 0);
    step(0, 1, 8'hE0, 0);
    step(0, 1, 8'hE0, 0);
    step(0, 1, 8'hF0, 0);
    check("seq_prefix_only", 0, 8'h00, 0, 0, 0, 0);
    step(0, 1, 8'h5A, 0);
    check("seq_ext_brk", 1, 8'h5A, 1, 1, 0, 1);
    step(0, 1, 8'hE0, 0);
    step(0, 1, 8'hFA, 0);
    step(0, 1, 8'h5A, 0);
    step(0, 1, 8'hF0, 0);
    step(0, 1, 8'hE1, 0);
    step(0, 1, 8'h6B, 0);
    step(0, 0, 8'h00, 0);
    check("seq_three_held", 1, 8'h5A, 1, 1, 0, 3);
    step(0, 0, 8'h00, 1);
    check("seq_pop_fa_abort", 1, 8'h5A, 0, 0, 0, 2);
    step(0, 0, 8'h00, 1);
    check("seq_pop_e1_abort", 1, 8'h6B, 0, 0, 0, 1);
    step(0, 0, 8'h00, 1);
    check("seq_drained", 0, 8'h6B, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
